alu_mc: RTL and testbench

Parametrised multi-cycle successor to the CPU's combinational 8-bit ALU. It supports a configurable datapath width and registers its result. It adds carry and zero flags, plus three iterative operations: shift-add multiply, variable left shift and variable right shift. It sits between the accumulator/operand registers and the control unit, which starts an operation and waits for `done`.

---
 rtl/alu_mc.sv | 158 +++++++++++++++
 tb/tb_alu_mc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered result with carry/zero flags, single-cycle logic ops,
// and iterative shift-add multiply and variable shifts handled by a two-state FSM.
module alu_mc #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             zero
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHL1 = 4'b0101;
    localparam logic [3:0] OP_SHR1 = 4'b0110;
    localparam logic [3:0] OP_SHL4 = 4'b0111;
    localparam logic [3:0] OP_ROL  = 4'b1000;
    localparam logic [3:0] OP_ROR  = 4'b1001;
    localparam logic [3:0] OP_DEC  = 4'b1010;
    localparam logic [3:0] OP_INV  = 4'b1011;
    localparam logic [3:0] OP_CLR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_SHLV = 4'b1110;
    localparam logic [3:0] OP_SHRV = 4'b1111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [3:0]           opreg;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     sreg;
    logic [CW-1:0]        cnt;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     res;
    logic                 cout;
    logic                 iterstart;

    logic [WIDTH:0]       msum;
    logic [2*WIDTH-1:0]   prodnext;
    logic [WIDTH-1:0]     shnext;
    logic                 shiftout;
    logic [WIDTH-1:0]     itery;
    logic                 iterc;

    // Single-cycle result straight from the live inputs; a zero-count shift passes A through.
    always_comb begin
        sum  = {1'b0, A} + {1'b0, B};
        res  = '0;
        cout = 1'b0;
        case (opcode)
            OP_ADD:  begin res = sum[WIDTH-1:0];            cout = sum[WIDTH];   end
            OP_SUB:  begin res = A - B;                     cout = (A < B);      end
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_SHL1: begin res = {A[WIDTH-2:0], 1'b0};      cout = A[WIDTH-1];   end
            OP_SHR1: begin res = {1'b0, A[WIDTH-1:1]};      cout = A[0];         end
            OP_SHL4: res = A << 4;
            OP_ROL:  begin res = {A[WIDTH-2:0], A[WIDTH-1]}; cout = A[WIDTH-1];  end
            OP_ROR:  begin res = {A[0], A[WIDTH-1:1]};      cout = A[0];         end
            OP_DEC:  begin res = A - WIDTH'(1);             cout = (A == '0);    end
            OP_INV:  res = ~A;
            OP_CLR:  res = '0;
            OP_SHLV, OP_SHRV: res = A;
            default: res = '0;
        endcase
    end

    assign iterstart = (opcode == OP_MUL) ||
                       (((opcode == OP_SHLV) || (opcode == OP_SHRV)) && (B[CW-1:0] != '0));

    // Multiplier: add multiplicand into the upper half when the low bit is set, then shift right.
    always_comb begin
        msum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prodnext = {msum, prod[WIDTH-1:1]};
        if (opreg == OP_SHLV) begin
            shnext   = {sreg[WIDTH-2:0], 1'b0};
            shiftout = sreg[WIDTH-1];
        end else begin
            shnext   = {1'b0, sreg[WIDTH-1:1]};
            shiftout = sreg[0];
        end
        if (opreg == OP_MUL) begin
            itery = prodnext[WIDTH-1:0];
            iterc = |prodnext[2*WIDTH-1:WIDTH];
        end else begin
            itery = shnext;
            iterc = shiftout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Y     <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
            opreg <= '0;
            mcand <= '0;
            prod  <= '0;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (iterstart) begin
                            opreg <= opcode;
                            mcand <= A;
                            prod  <= {{WIDTH{1'b0}}, B};
                            sreg  <= A;
                            cnt   <= (opcode == OP_MUL) ? CW'(WIDTH - 1) : B[CW-1:0] - CW'(1);
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            Y     <= res;
                            carry <= cout;
                            zero  <= (res == '0);
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    prod <= prodnext;
                    sreg <= shnext;
                    if (cnt == '0) begin
                        Y     <= itery;
                        carry <= iterc;
                        zero  <= (itery == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: expected results are queued at stimulus time and
// compared against Y/carry/zero whenever done pulses.
module tb_alu_mc;

    localparam int W  = 8;
    localparam int CW = 3;

    typedef struct {
        logic [W-1:0] y;
        logic         c;
        logic         z;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   opcode;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Y;
    logic         carry;
    logic         zero;

    int   vectors;
    int   miscompares;
    exp_t sb[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Y      (Y),
        .carry  (carry),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {carry, result}
    function automatic logic [W:0] refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        logic           c;
        int             n;
        r = '0;
        c = 1'b0;
        n = int'(b[CW-1:0]);
        case (op)
            4'd0:  {c, r} = {1'b0, a} + {1'b0, b};
            4'd1:  begin r = a - b; c = (a < b); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  begin r = a << 1; c = a[W-1]; end
            4'd6:  begin r = a >> 1; c = a[0]; end
            4'd7:  r = a << 4;
            4'd8:  begin r = {a[W-2:0], a[W-1]}; c = a[W-1]; end
            4'd9:  begin r = {a[0], a[W-1:1]}; c = a[0]; end
            4'd10: begin r = a - W'(1); c = (a == '0); end
            4'd11: r = ~a;
            4'd12: r = '0;
            4'd13: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = p[W-1:0];
                c = |p[2*W-1:W];
            end
            4'd14: begin r = a << n; c = (n == 0) ? 1'b0 : a[W-n]; end
            default: begin r = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
        endcase
        return {c, r};
    endfunction

    task automatic pushExpected(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] m;
        exp_t       e;
        m   = refModel(op, a, b);
        e.y = m[W-1:0];
        e.c = m[W];
        e.z = (m[W-1:0] == '0);
        sb.push_back(e);
    endtask

    // Entered and left on a falling edge; scrambles inputs after acceptance.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int expLat;
        int lat;
        int busyCnt;
        if (op == 4'd13)
            expLat = W + 1;
        else if (op >= 4'd14 && b[CW-1:0] != '0)
            expLat = int'(b[CW-1:0]) + 1;
        else
            expLat = 1;
        pushExpected(op, a, b);
        opcode = op;
        A      = a;
        B      = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        opcode = 4'($urandom);
        A      = W'($urandom);
        B      = W'($urandom);
        lat     = 1;
        busyCnt = 0;
        while (!done && lat <= 2 * W + 2) begin
            if (busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_busycycles"}, 32'(busyCnt), 32'(expLat - 1));
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    // Scoreboard: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (done) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("[TB] FAIL spurious_done observed=1 expected=0");
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_Y", 32'(Y), 32'(e.y));
                checkOutput("sb_carry", 32'(carry), 32'(e.c));
                checkOutput("sb_zero", 32'(zero), 32'(e.z));
            end
        end
    end

    initial begin
        int doneCnt;
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        start  = 1'b0;
        opcode = '0;
        A      = '0;
        B      = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_Y", 32'(Y), 32'd0);
        checkOutput("reset_flags", 32'({carry, zero}), 32'd0);

        // Load non-zero state, then hit reset between clock edges
        applyStimulus(4'd0, 8'hFF, 8'h02, "add_pre");
        #2 rst = 1'b1;
        #1;
        checkOutput("async_Y", 32'(Y), 32'd0);
        checkOutput("async_flags", 32'({busy, done, carry, zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(4'd0, 8'hFF, 8'h01, "add_wrap");
        checkOutput("add_wrap_Y", 32'(Y), 32'h00);
        checkOutput("add_wrap_cz", 32'({carry, zero}), 32'b11);
        applyStimulus(4'd1, 8'h05, 8'h07, "sub_borrow");
        checkOutput("sub_Y", 32'(Y), 32'hFE);
        checkOutput("sub_cz", 32'({carry, zero}), 32'b10);
        applyStimulus(4'd10, 8'h00, 8'h00, "dec_zero");
        checkOutput("dec_Y", 32'(Y), 32'hFF);
        checkOutput("dec_c", 32'(carry), 32'd1);

        for (int op = 2; op <= 12; op++)
            applyStimulus(4'(op), W'($urandom), W'($urandom), $sformatf("op%0d", op));
        applyStimulus(4'd5, 8'h80, 8'h00, "shl1_edge");
        applyStimulus(4'd9, 8'h01, 8'h00, "ror_edge");

        applyStimulus(4'd13, 8'h0D, 8'h0B, "mul_a");
        checkOutput("mul_a_Y", 32'(Y), 32'h8F);
        checkOutput("mul_a_c", 32'(carry), 32'd0);
        applyStimulus(4'd13, 8'h20, 8'h10, "mul_b");
        checkOutput("mul_b_Y", 32'(Y), 32'h00);
        checkOutput("mul_b_cz", 32'({carry, zero}), 32'b11);
        applyStimulus(4'd13, 8'hFF, 8'hFF, "mul_max");

        applyStimulus(4'd14, 8'h81, 8'h03, "shlv3");
        checkOutput("shlv3_Y", 32'(Y), 32'h08);
        checkOutput("shlv3_c", 32'(carry), 32'd0);
        applyStimulus(4'd15, 8'h81, 8'h00, "shrv0");
        checkOutput("shrv0_Y", 32'(Y), 32'h81);
        applyStimulus(4'd15, 8'h81, 8'h07, "shrv7");
        applyStimulus(4'd14, 8'hC3, 8'hF9, "shlv_hi_ignored");
        applyStimulus(4'd15, 8'hA6, 8'h02, "shrv2");

        // Two single-cycle ops back to back: done stays high two cycles
        opcode = 4'd0; A = 8'h10; B = 8'h20; start = 1'b1;
        pushExpected(4'd0, 8'h10, 8'h20);
        @(negedge clk);
        opcode = 4'd1; A = 8'h30; B = 8'h40;
        pushExpected(4'd1, 8'h30, 8'h40);
        checkOutput("b2b_done1", 32'(done), 32'd1);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_done2", 32'(done), 32'd1);
        @(negedge clk);
        checkOutput("b2b_done3", 32'(done), 32'd0);

        // A start pulse while busy must be ignored
        opcode = 4'd13; A = 8'h03; B = 8'h05; start = 1'b1;
        pushExpected(4'd13, 8'h03, 8'h05);
        doneCnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
            if (i == 0) begin
                opcode = 4'd0; A = 8'hAA; B = 8'h55; start = 1'b1;
            end else begin
                start = 1'b0; A = W'($urandom); B = W'($urandom);
            end
        end
        checkOutput("ignore_done_count", 32'(doneCnt), 32'd1);
        checkOutput("ignore_Y", 32'(Y), 32'h0F);

        // Reset during a multiply aborts it with no completion
        opcode = 4'd13; A = 8'h0D; B = 8'h0B; start = 1'b1;
        pushExpected(4'd13, 8'h0D, 8'h0B);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("abort_Y", 32'(Y), 32'd0);
        checkOutput("abort_flags", 32'({busy, done, carry, zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        doneCnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
        applyStimulus(4'd0, 8'h02, 8'h03, "add_after_abort");
        checkOutput("add_after_abort_Y", 32'(Y), 32'h05);

        repeat (2) @(negedge clk);
        checkOutput("sb_empty_at_end", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
